spi_slave_top: RTL

SPI target (slave) that answers the team's SPI master. All SPI pins are sampled on the system clock through synchronizers, so there is no SPI-clock domain. It supports all four CPOL/CPHA modes, MSB first, and multiple back-to-back words per chip-select frame. The user side has a one-word TX holding register with a valid/ready handshake and a single-cycle RX valid pulse.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_input_sync.sv | 32 +++
 rtl/spi_slave_top.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the SPI target and the SPI master.
package spi_pkg;

    // Frame-level state of an SPI endpoint
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    // Clock mode latched at the start of each frame
    typedef struct packed {
        logic polarity;
        logic phase;
    } spi_mode_t;

    localparam int unsigned DEFAULT_SPI_DATA_WIDTH = 8;

endpackage

// File: rtl/spi_input_sync.sv
// N-stage synchronizer for an asynchronous pin, followed by a rise/fall edge detector.
module spi_input_sync #(
    parameter int unsigned STAGES      = 2,
    parameter logic        RESET_VALUE = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the pin through the synchronizer chain and keep the previous level for edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RESET_VALUE}};
            prev_q <= RESET_VALUE;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_top.sv
// SPI target: oversampled SPI pins, all four CPOL/CPHA modes, MSB first,
// back-to-back words per frame, one-word TX holding register.
module spi_slave_top
    import spi_pkg::*;
#(
    parameter int unsigned SPI_DATA_WIDTH = DEFAULT_SPI_DATA_WIDTH,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_clock_polarity,
    input  logic                      i_clock_phase,
    input  logic [SPI_DATA_WIDTH-1:0] i_tx_data,
    input  logic                      i_tx_valid,
    output logic                      o_tx_ready,
    output logic [SPI_DATA_WIDTH-1:0] o_rx_data,
    output logic                      o_rx_valid,
    output logic                      o_underrun,
    output logic                      o_frame_error,
    output logic                      o_busy,
    input  logic                      i_spi_cs_n,
    input  logic                      i_spi_clock,
    input  logic                      i_spi_mosi,
    output logic                      o_spi_miso,
    output logic                      o_spi_miso_oe
);

    localparam int unsigned         CNT_W    = $clog2(SPI_DATA_WIDTH);
    localparam logic [CNT_W-1:0]    LAST_BIT = CNT_W'(SPI_DATA_WIDTH - 1);

    logic cs_level, cs_rise, cs_fall;
    logic sclk_level, sclk_rise, sclk_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic unused_sync;

    spi_state_e state_q, state_d;
    spi_mode_t  mode_q;

    logic [CNT_W-1:0]          bit_cnt_q;
    logic [SPI_DATA_WIDTH-1:0] rx_shift_q, rx_data_q, tx_shift_q, hold_q;
    logic                      word_done_q, rx_valid_q, hold_full_q;
    logic                      underrun_q, frame_err_q;

    logic enter, leave, sample_edge, shift_edge, fetch, tx_write;

    // cs_n resets low so a chip select still asserted across reset produces no
    // falling edge; the frame is only picked up after cs_n has been seen high.
    spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_cs (
        .clk_i(i_clock), .rst_i(i_reset), .pin_i(i_spi_cs_n),
        .level_o(cs_level), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_sclk (
        .clk_i(i_clock), .rst_i(i_reset), .pin_i(i_spi_clock),
        .level_o(sclk_level), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_mosi (
        .clk_i(i_clock), .rst_i(i_reset), .pin_i(i_spi_mosi),
        .level_o(mosi_level), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    assign unused_sync = ^{cs_level, sclk_level, mosi_rise, mosi_fall};

    // Frame state register
    always_ff @(posedge i_clock) begin
        if (i_reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Frame boundaries follow the synchronized chip select edges
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (cs_fall) state_d = ACTIVE;
            ACTIVE: if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decode frame strobes, sample/shift edges and word fetch points
    always_comb begin
        enter       = 1'b0;
        leave       = 1'b0;
        sample_edge = 1'b0;
        shift_edge  = 1'b0;
        if (state_q == IDLE) begin
            enter = cs_fall;
        end else begin
            leave = cs_rise;
            // leading edge leaves the idle level, trailing edge returns to it
            if (mode_q.phase) begin
                sample_edge = mode_q.polarity ? sclk_rise : sclk_fall;
                shift_edge  = mode_q.polarity ? sclk_fall : sclk_rise;
            end else begin
                sample_edge = mode_q.polarity ? sclk_fall : sclk_rise;
                shift_edge  = mode_q.polarity ? sclk_rise : sclk_fall;
            end
        end
        // A shift edge with a cleared counter is the word boundary for both
        // phases: for CPHA=0 it follows a completed word, for CPHA=1 it starts one.
        fetch = (enter && !i_clock_phase) || (shift_edge && (bit_cnt_q == '0));
    end

    assign o_tx_ready = !hold_full_q || fetch;
    assign tx_write   = i_tx_valid && o_tx_ready;

    // Datapath: mode latch, RX shifter and counter, TX shifter, holding register, status pulses
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            mode_q      <= '0;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            word_done_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            word_done_q <= 1'b0;
            rx_valid_q  <= word_done_q;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;

            if (word_done_q) rx_data_q <= rx_shift_q;

            if (enter) begin
                mode_q.polarity <= i_clock_polarity;
                mode_q.phase    <= i_clock_phase;
                bit_cnt_q       <= '0;
            end else if (leave) begin
                frame_err_q <= (bit_cnt_q != '0);
                bit_cnt_q   <= '0;
            end else if (sample_edge) begin
                rx_shift_q <= {rx_shift_q[SPI_DATA_WIDTH-2:0], mosi_level};
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_q   <= '0;
                    word_done_q <= 1'b1;
                end else begin
                    bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                end
            end

            if (fetch) begin
                tx_shift_q <= hold_full_q ? hold_q : '0;
                underrun_q <= !hold_full_q;
            end else if (shift_edge) begin
                tx_shift_q <= tx_shift_q << 1;
            end

            if (tx_write) begin
                hold_q      <= i_tx_data;
                hold_full_q <= 1'b1;
            end else if (fetch) begin
                hold_full_q <= 1'b0;
            end
        end
    end

    assign o_rx_data     = rx_data_q;
    assign o_rx_valid    = rx_valid_q;
    assign o_underrun    = underrun_q;
    assign o_frame_error = frame_err_q;
    assign o_busy        = (state_q == ACTIVE);
    assign o_spi_miso    = tx_shift_q[SPI_DATA_WIDTH-1];
    assign o_spi_miso_oe = (state_q == ACTIVE);

endmodule
